// File: rtl/switch_key_input.sv
// Bus-readable switch/key input port: two-flop synchroniser, group debounce,
// and a change interrupt with write-1-to-clear pending flag.
module switch_key_input #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [3:0]  byteen,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  input  logic [63:0] DipSwitch,
  input  logic [7:0]  UserKey,
  output logic        IRQ
);

  localparam logic [CNT_W-1:0] LP_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [71:0]      r_sync1;
  logic [71:0]      r_sync2;
  logic [71:0]      r_cand;
  logic [71:0]      r_deb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  logic             r_ie;

  logic w_load;
  logic w_event;
  logic w_ctrl_wr;
  logic w_clr;
  logic w_unused_bits;

  // Pins idle high, so the pipeline resets to ones and the count starts
  // from scratch after every reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_cand  <= '1;
      r_deb   <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= {UserKey, DipSwitch};
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt == LP_TC) begin
        r_deb <= ~r_cand;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_load    = (r_sync2 == r_cand) && (r_cnt == LP_TC);
  assign w_event   = w_load && ((~r_cand) != r_deb);
  assign w_ctrl_wr = WE && (Addr == 2'd3) && byteen[0];
  assign w_clr     = w_ctrl_wr && WD[0];

  // A new event outranks a simultaneous clear so no change is lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend <= 1'b0;
      r_ie   <= 1'b0;
    end else begin
      if (w_event && r_ie) begin
        r_pend <= 1'b1;
      end else if (w_clr) begin
        r_pend <= 1'b0;
      end
      if (w_ctrl_wr) begin
        r_ie <= WD[1];
      end
    end
  end

  always_comb begin
    RD = '0;
    case (Addr)
      2'd0:    RD = r_deb[31:0];
      2'd1:    RD = r_deb[63:32];
      2'd2:    RD = {24'b0, r_deb[71:64]};
      default: RD = {30'b0, r_ie, r_pend};
    endcase
  end

  assign IRQ = r_pend & r_ie;

  assign w_unused_bits = ^{WD[31:2], byteen[3:1]};

endmodule

// File: doc/switch_key_input.md
Name: switch_key_input

Overview:
- Memory-mapped input peripheral on the CPU system bridge. It is the read-side counterpart of the LED output device.
- Samples the board's 64 DIP switches and 8 user keys, synchronises them to clk, and debounces them as one group.
- Exposes the debounced values as bus-readable registers.
- Raises a level interrupt request when any debounced input changes, if interrupts are enabled.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed before the debounced value updates. Minimum 2. Board build uses 200000.
- CNT_W, 20, width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset (0 = reset asserted).
- Addr  input  2  word select within the 16-byte window (byte address bits [3:2]).
- WE  input  1  bus write enable.
- byteen  input  4  byte enables of the write.
- WD  input  32  write data.
- RD  output  32  read data for the word selected by Addr (combinational).
- DipSwitch  input  64  raw switch pins, active-low at the pin.
- UserKey  input  8  raw key pins, active-low at the pin.
- IRQ  output  1  interrupt request, level, active-high.

Behaviour:
- Register map (by Addr):
  - 0 (0x0) SW_LO: debounced ~DipSwitch[31:0].
  - 1 (0x4) SW_HI: debounced ~DipSwitch[63:32].
  - 2 (0x8) KEY: {24'b0, debounced ~UserKey}.
  - 3 (0xC) CTRL: {30'b0, ie, pend}.
- Input path:
  - The 72-bit vector {UserKey, DipSwitch} passes through two flops, sync1 then sync2.
  - A candidate register cand holds the last sync2 value.
- Debounce, evaluated every cycle when not in reset:
  - If sync2 != cand: cand <= sync2 and cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: deb <= ~cand and cnt holds.
  - Else: cnt <= cnt+1.
- Latency: a pin change held stable appears in deb exactly DEBOUNCE_CYCLES+3 clock edges after the first edge that samples it.
- A glitch shorter than DEBOUNCE_CYCLES+1 cycles never reaches deb; cnt restarts on every change.
- Change event: asserted in the cycle deb is loaded with a value different from its current value. Reloading an identical value is not an event.
- pend:
  - Set on a change event when ie = 1. Events with ie = 0 are dropped, not latched.
  - Cleared by a bus write with WE=1, Addr=3, byteen[0]=1, WD[0]=1 (write-1-to-clear).
  - If clear and a change event occur in the same cycle, set wins and pend = 1.
- ie: loaded from WD[1] on any write with WE=1, Addr=3, byteen[0]=1. Writing ie=0 does not clear pend.
- IRQ = pend & ie. It is registered-state derived and glitch-free.
- Writes to Addr 0–2, and writes to Addr 3 with byteen[0]=0, have no effect.
- RD is combinational from the registers; read data is valid in the same cycle.
- Reset (reset=0 at a clk edge):
  - sync1, sync2 and cand go to all ones (inactive pin level).
  - deb = 0, cnt = 0, pend = 0, ie = 0.
  - So RD returns 0 for all words and IRQ = 0.
- Reset mid-debounce discards the partial count. After reset release, pins already active at release are reported after DEBOUNCE_CYCLES+3 edges and generate an event only if ie was set by then.
- Wide switch changes across many bits in one cycle produce one event. Changes during an active count restart the count and still produce a single event when stable.

Test Plan:
- Reset hold then release with all pins high → RD=0 at Addr 0,1,2,3; IRQ=0; stays 0 for 50 cycles.
- DEBOUNCE_CYCLES=4; drive DipSwitch[7:0]=8'h5A (others high) at edge 0 → SW_LO reads 0x000000A5 from edge 7 onward, reads 0 at edge 6.
- UserKey[0] pulse low for 4 cycles, then high → KEY stays 0 and no event. Pulse low for 10 cycles → KEY=0x1 from edge 7 and back to 0 seven edges after release.
- Write CTRL=0x2 (ie=1), then change DipSwitch[40] → SW_HI bit 8 = 1, pend=1, IRQ=1. Write CTRL=0x3 → pend=0, IRQ=0, ie still 1.
- With ie=1 and pend=1, issue the W1C write in the same cycle as a new debounced change → pend remains 1 and IRQ remains 1.
- Write CTRL=0x3 with byteen=4'b0010 → no change. Write 0xFFFFFFFF to Addr 0 → SW_LO unchanged. Assert reset mid-count, then release → cnt restarts and no stale update appears.
